// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: queue entry type and PC helper shared by the fetch unit.
`include "ifu_defines.sv"
package ifu_fetch_pkg;
    // Response queue entry: fetch address in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [`RegBus] addr;
        logic [`RegBus] inst;
    } fetch_ent_t;
    localparam int ENT_W = $bits(fetch_ent_t);
    function automatic logic [`RegBus] next_pc(input logic [`RegBus] pc);
        return pc + 32'(`FETCH_STEP);
    endfunction
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction bus (req/gnt/rvalid).
// master: req, addr out; gnt, rvalid, rdata in. slave: the reverse.
`include "ifu_defines.sv"
interface ifu_fetch_if;
    logic           req;
    logic [`RegBus] addr;
    logic           gnt;
    logic           rvalid;
    logic [`RegBus] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifu_defines.sv
// ifu_defines: shared bus widths, instruction constants and fetch step for the IFU slice.
`ifndef IFU_DEFINES_SV
`define IFU_DEFINES_SV
`define RegBus 31:0
`define Hold_Bus 5:0
`define INST_NOP 32'h0000_0013
`define ZeroWord 32'h0000_0000
`define Enable 1'b1
`define Disable 1'b0
`define FETCH_STEP 4
`endif

// File: rtl/ifu_queue.sv
// ifu_queue: synchronous FIFO with clear; head is read combinationally.
// Ports: clk, rstn (async active-low), clear, push, pop, din -> head, count.
// Push into a full FIFO is accepted only together with a pop; pop on empty is ignored.
module ifu_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic do_pop, do_push;
    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CNT_W'(DEPTH) || do_pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) rd_ptr <= inc(rd_ptr);
            if (do_push) wr_ptr <= inc(wr_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and instruction fetcher feeding the IF/ID register.
// Ports: clk, rstn (async active-low), hold (any bit stalls), jump_en/jump_addr (redirect),
//        ibus (fetch bus master), inst_o/addr_o/inst_valid_o (queue head to IF/ID).
`include "ifu_defines.sv"
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter int          CNT_W      = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [`Hold_Bus] hold,
    input  logic             jump_en,
    input  logic [`RegBus]   jump_addr,
    ifu_fetch_if.master      ibus,
    output logic [`RegBus]   inst_o,
    output logic [`RegBus]   addr_o,
    output logic             inst_valid_o
);
    logic             stall, fire, rsp, keep, pop;
    logic [`RegBus]   pc, af_head;
    logic [CNT_W-1:0] outstanding, discard, out_nxt, q_count, af_count;
    logic [CNT_W:0]   credit_used;
    fetch_ent_t       q_head;
    assign stall       = |hold;
    // In-flight requests plus buffered words never exceed DEPTH, so every response has a slot.
    assign credit_used = {1'b0, outstanding} + {1'b0, q_count};
    assign ibus.req    = rstn && !stall && !jump_en && credit_used < (CNT_W + 1)'(DEPTH);
    assign ibus.addr   = pc;
    assign fire        = ibus.req && ibus.gnt;
    // A response is only meaningful when an address is waiting to be paired with it.
    assign rsp         = ibus.rvalid && af_count != '0;
    assign keep        = rsp && discard == '0;
    assign pop         = q_count != '0 && !stall && !jump_en;
    assign out_nxt     = outstanding + CNT_W'(fire) - CNT_W'(rsp);
    assign inst_valid_o = q_count != '0 && !jump_en;
    assign inst_o      = inst_valid_o ? q_head.inst : `INST_NOP;
    assign addr_o      = inst_valid_o ? q_head.addr : `ZeroWord;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_nxt;
            pc          <= jump_en ? jump_addr : fire ? next_pc(pc) : pc;
            // On a redirect every request still in flight after this cycle is stale.
            discard     <= jump_en ? out_nxt : (rsp && discard != '0) ? discard - CNT_W'(1) : discard;
        end
    end
    // The address FIFO is never cleared: it must stay paired with responses still on the bus.
    ifu_queue #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_addr_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (1'b0),
        .push  (fire),
        .pop   (rsp),
        .din   (pc),
        .head  (af_head),
        .count (af_count)
    );
    ifu_queue #(.WIDTH(ENT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_resp_q (
        .clk   (clk),
        .rstn  (rstn),
        .clear (jump_en),
        .push  (keep),
        .pop   (pop),
        .din   ({af_head, ibus.rdata}),
        .head  (q_head),
        .count (q_count)
    );
endmodule
